// File: rtl/ball_pkg.sv
// Shared types and helpers for the ball physics engine: FSM states, map cell
// codes and the accelerometer-to-step conversion.
package ball_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    X_REQ,
    X_CHK,
    Y_REQ,
    Y_CHK,
    G_REQ,
    G_CHK
  } ball_state_e;

  localparam logic [7:0] WALL_CODE = 8'd2;
  localparam logic [7:0] GOAL_CODE = 8'd3;

  // Tilt offset to unsigned step size: dead-band, coarse shift, saturate.
  function automatic int unsigned step_mag(input int          d,
                                           input int unsigned dead_band,
                                           input int unsigned shift,
                                           input int unsigned max_step);
    int unsigned a;
    a = (d < 0) ? unsigned'(-d) : unsigned'(d);
    if (a <= dead_band) return 0;
    a = a >> shift;
    return (a > max_step) ? max_step : a;
  endfunction

endpackage

// File: rtl/ball_tick_gen.sv
// Free-running divider producing a one-cycle physics tick at the top count.
module ball_tick_gen #(
  parameter int unsigned CLK_FREQUENCY_HZ       = 100000000,
  parameter int unsigned UPDATE_FREQUENCY_HZ    = 20,
  parameter int unsigned CNTR_WIDTH             = 32,
  parameter int unsigned SIMULATE               = 0,
  parameter int unsigned SIMULATE_FREQUENCY_CNT = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int unsigned TOP_CNT = (SIMULATE != 0) ? SIMULATE_FREQUENCY_CNT
                                  : (CLK_FREQUENCY_HZ / UPDATE_FREQUENCY_HZ) - 1;
  localparam logic [CNTR_WIDTH-1:0] TOP = CNTR_WIDTH'(TOP_CNT);

  logic [CNTR_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (cnt_q == TOP) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == TOP);

endmodule

// File: rtl/ball_motion_ctrl.sv
// Ball physics engine: per tick converts tilt to a step per axis, probes the
// world map for walls (backing the step off), commits the position, checks goal.
module ball_motion_ctrl
  import ball_pkg::*;
#(
  parameter int CLK_FREQUENCY_HZ       = 100000000,
  parameter int UPDATE_FREQUENCY_HZ    = 20,
  parameter int CNTR_WIDTH             = 32,
  parameter int SIMULATE               = 0,
  parameter int SIMULATE_FREQUENCY_CNT = 5,
  parameter int ACCEL_WIDTH            = 9,
  parameter int ACCEL_CENTER           = 256,
  parameter int DEAD_BAND              = 32,
  parameter int STEP_SHIFT             = 5,
  parameter int MAX_STEP               = 4,
  parameter int X_WIDTH                = 10,
  parameter int Y_WIDTH                = 9,
  parameter int X_MAX                  = 639,
  parameter int Y_MAX                  = 479,
  parameter int X_INIT                 = 16,
  parameter int Y_INIT                 = 16,
  parameter int MAP_LATENCY            = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   restart,
  input  logic [ACCEL_WIDTH-1:0] accelX_IN,
  input  logic [ACCEL_WIDTH-1:0] accelY_IN,
  output logic [X_WIDTH-1:0]     map_col,
  output logic [Y_WIDTH-1:0]     map_row,
  input  logic [7:0]             map_loc_info,
  output logic [X_WIDTH-1:0]     x_out,
  output logic [Y_WIDTH-1:0]     y_out,
  output logic                   busy,
  output logic                   at_goal
);

  localparam int unsigned MAG_W = $clog2(MAX_STEP + 1);
  localparam int unsigned LAT_W = (MAP_LATENCY > 1) ? $clog2(MAP_LATENCY) : 1;
  localparam logic [LAT_W-1:0]   LAT_TOP = LAT_W'(MAP_LATENCY - 1);
  localparam logic [X_WIDTH:0]   X_LIM   = (X_WIDTH + 1)'(X_MAX);
  localparam logic [Y_WIDTH:0]   Y_LIM   = (Y_WIDTH + 1)'(Y_MAX);

  ball_state_e          state_q;
  logic [MAG_W-1:0]     magx_q, magy_q;
  logic                 negx_q, negy_q;
  logic [LAT_W-1:0]     lat_q;
  logic [X_WIDTH-1:0]   x_q, map_col_q;
  logic [Y_WIDTH-1:0]   y_q, map_row_q;
  logic                 busy_q, at_goal_q;
  logic                 tick;

  int                   dx, dy;
  logic [MAG_W-1:0]     magx_d, magy_d, magx_dec, magy_dec;
  logic                 negx_d, negy_d, wall;
  logic [X_WIDTH-1:0]   x_chk_d;
  logic [Y_WIDTH-1:0]   y_chk_d;

  ball_tick_gen #(
    .CLK_FREQUENCY_HZ      (CLK_FREQUENCY_HZ),
    .UPDATE_FREQUENCY_HZ   (UPDATE_FREQUENCY_HZ),
    .CNTR_WIDTH            (CNTR_WIDTH),
    .SIMULATE              (SIMULATE),
    .SIMULATE_FREQUENCY_CNT(SIMULATE_FREQUENCY_CNT)
  ) u_tick (
    .clk_i (clk),
    .rst_ni(reset),
    .tick_o(tick)
  );

  // Candidate column: one bit of headroom, saturated to [0, X_MAX].
  function automatic logic [X_WIDTH-1:0] cand_x(input logic [X_WIDTH-1:0] pos,
                                                input logic neg,
                                                input logic [MAG_W-1:0] mag);
    logic [X_WIDTH:0] p, m;
    p = {1'b0, pos};
    m = (X_WIDTH + 1)'(mag);
    if (neg) return (p < m) ? '0 : X_WIDTH'(p - m);
    return ((p + m) > X_LIM) ? X_WIDTH'(X_MAX) : X_WIDTH'(p + m);
  endfunction

  function automatic logic [Y_WIDTH-1:0] cand_y(input logic [Y_WIDTH-1:0] pos,
                                                input logic neg,
                                                input logic [MAG_W-1:0] mag);
    logic [Y_WIDTH:0] p, m;
    p = {1'b0, pos};
    m = (Y_WIDTH + 1)'(mag);
    if (neg) return (p < m) ? '0 : Y_WIDTH'(p - m);
    return ((p + m) > Y_LIM) ? Y_WIDTH'(Y_MAX) : Y_WIDTH'(p + m);
  endfunction

  always_comb begin
    dx       = int'({1'b0, accelX_IN}) - ACCEL_CENTER;
    dy       = int'({1'b0, accelY_IN}) - ACCEL_CENTER;
    magx_d   = MAG_W'(step_mag(dx, unsigned'(DEAD_BAND), unsigned'(STEP_SHIFT),
                               unsigned'(MAX_STEP)));
    magy_d   = MAG_W'(step_mag(dy, unsigned'(DEAD_BAND), unsigned'(STEP_SHIFT),
                               unsigned'(MAX_STEP)));
    negx_d   = (dx < 0);
    negy_d   = (dy < 0);
    wall     = (map_loc_info == WALL_CODE);
    // The probed candidate sits in the address register, so a clear cell commits it.
    x_chk_d  = wall ? x_q : map_col_q;
    y_chk_d  = wall ? y_q : map_row_q;
    magx_dec = magx_q - 1'b1;
    magy_dec = magy_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      magx_q    <= '0;
      magy_q    <= '0;
      negx_q    <= 1'b0;
      negy_q    <= 1'b0;
      lat_q     <= '0;
      x_q       <= X_WIDTH'(X_INIT);
      y_q       <= Y_WIDTH'(Y_INIT);
      map_col_q <= '0;
      map_row_q <= '0;
      busy_q    <= 1'b0;
      at_goal_q <= 1'b0;
    end else if (restart) begin
      state_q   <= IDLE;
      x_q       <= X_WIDTH'(X_INIT);
      y_q       <= Y_WIDTH'(Y_INIT);
      busy_q    <= 1'b0;
      at_goal_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (tick) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
          end
        end
        CALC: begin
          magx_q <= magx_d;
          magy_q <= magy_d;
          negx_q <= negx_d;
          negy_q <= negy_d;
          lat_q  <= LAT_TOP;
          if (magx_d != '0) begin
            state_q   <= X_REQ;
            map_col_q <= cand_x(x_q, negx_d, magx_d);
            map_row_q <= y_q;
          end else if (magy_d != '0) begin
            state_q   <= Y_REQ;
            map_col_q <= x_q;
            map_row_q <= cand_y(y_q, negy_d, magy_d);
          end else begin
            state_q   <= G_REQ;
            map_col_q <= x_q;
            map_row_q <= y_q;
          end
        end
        X_REQ, Y_REQ, G_REQ: begin
          if (lat_q == '0) begin
            state_q <= (state_q == X_REQ) ? X_CHK :
                       (state_q == Y_REQ) ? Y_CHK : G_CHK;
          end else begin
            lat_q <= lat_q - 1'b1;
          end
        end
        X_CHK: begin
          lat_q <= LAT_TOP;
          if (wall && (magx_q > MAG_W'(1))) begin
            state_q   <= X_REQ;
            magx_q    <= magx_dec;
            map_col_q <= cand_x(x_q, negx_q, magx_dec);
          end else begin
            x_q       <= x_chk_d;
            map_col_q <= x_chk_d;
            if (magy_q != '0) begin
              state_q   <= Y_REQ;
              map_row_q <= cand_y(y_q, negy_q, magy_q);
            end else begin
              state_q   <= G_REQ;
              map_row_q <= y_q;
            end
          end
        end
        Y_CHK: begin
          lat_q     <= LAT_TOP;
          map_col_q <= x_q;
          if (wall && (magy_q > MAG_W'(1))) begin
            state_q   <= Y_REQ;
            magy_q    <= magy_dec;
            map_row_q <= cand_y(y_q, negy_q, magy_dec);
          end else begin
            state_q   <= G_REQ;
            y_q       <= y_chk_d;
            map_row_q <= y_chk_d;
          end
        end
        G_CHK: begin
          if (map_loc_info == GOAL_CODE) at_goal_q <= 1'b1;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign map_col = map_col_q;
  assign map_row = map_row_q;
  assign x_out   = x_q;
  assign y_out   = y_q;
  assign busy    = busy_q;
  assign at_goal = at_goal_q;

endmodule
